// File: rtl/ctrl_pkg.sv
// Shared definitions for the FemtoRV32 control pipeline: opcodes, the
// control bundle layout, halt causes and the halt FSM state encoding.
package ctrl_pkg;

  // Width of the control bundle carried down the pipe
  localparam int CTRL_BUNDLE_W = 13;

  // instr[6:2] opcode values understood by the decoder
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // Bit offsets of each field inside the bundle
  localparam int B_BRANCH   = 12;
  localparam int B_MEMREAD  = 11;
  localparam int B_MEMTOREG = 10;
  localparam int B_ALUOP_HI = 9;
  localparam int B_ALUOP_LO = 8;
  localparam int B_MEMWRITE = 7;
  localparam int B_ALUSRC   = 6;
  localparam int B_REGWRITE = 5;
  localparam int B_ITYPE    = 4;
  localparam int B_AJ_HI    = 3;
  localparam int B_AJ_LO    = 2;
  localparam int B_LUI      = 1;
  localparam int B_SPARE    = 0;

  // Field encodings
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_JAL  = 2'b11;
  localparam logic [1:0] AJ_NONE    = 2'b00;
  localparam logic [1:0] AJ_JUMP    = 2'b01;
  localparam logic [1:0] AJ_AUIPC   = 2'b11;

  // Packed view of the bundle; field order matches the offsets above
  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       i_type;
    logic [1:0] aj;
    logic       lui;
    logic       spare;
  } ctrl_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_SYS  = 2'b01,
    CAUSE_ILL  = 2'b10
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instr[6:2] -> control bundle plus the
// SYSTEM and illegal-opcode markers. Marked opcodes decode to all zeros.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]               opcode,
  output logic [CTRL_BUNDLE_W-1:0] ctrl,
  output logic                     sys,
  output logic                     ill
);

  ctrl_t c;

  // Decode table; every output defaults to zero so nothing latches
  always_comb begin
    c   = '0;
    sys = 1'b0;
    ill = 1'b0;
    unique case (opcode)
      OPC_R: begin
        c.aluop    = ALUOP_FUNC;
        c.regwrite = 1'b1;
      end
      OPC_LOAD: begin
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
      end
      OPC_STORE: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        c.aluop  = ALUOP_BR;
      end
      OPC_OPIMM: begin
        c.aluop    = ALUOP_FUNC;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.i_type   = 1'b1;
      end
      OPC_JAL: begin
        c.branch   = 1'b1;
        c.aluop    = ALUOP_JAL;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aj       = AJ_JUMP;
      end
      OPC_JALR: begin
        c.aluop    = ALUOP_FUNC;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aj       = AJ_JUMP;
      end
      OPC_AUIPC: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aj       = AJ_AUIPC;
      end
      OPC_LUI: begin
        c.aluop    = ALUOP_FUNC;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.lui      = 1'b1;
      end
      OPC_SYSTEM: begin
        sys = 1'b1;
      end
      default: begin
        ill = 1'b1;
      end
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Registered control decode for the pipelined FemtoRV32 core. Carries the
// decoded bundle through STAGES registers with per-stage flush, and halts
// the core once a SYSTEM (or trapped illegal) instruction has drained out.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int CTRL_W   = 13,
  parameter bit TRAP_ILL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [4:0]               id_opcode,
  input  logic                     stall_id,
  input  logic [STAGES-1:0]        flush,
  output logic                     id_ready,
  output logic [STAGES*CTRL_W-1:0] stg_ctrl,
  output logic [STAGES-1:0]        stg_valid,
  output logic                     halted,
  output logic [1:0]               halt_cause
);

  generate
    if (CTRL_W != CTRL_BUNDLE_W) begin : g_bad_ctrl_w
      $error("ctrl_pipe_unit: CTRL_W must equal the package bundle width");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("ctrl_pipe_unit: STAGES must be in 1..4");
    end
  endgenerate

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_sys;
  logic              dec_ill;

  ctrl_decode u_decode (
    .opcode (id_opcode),
    .ctrl   (dec_ctrl),
    .sys    (dec_sys),
    .ill    (dec_ill)
  );

  state_e            state_q, state_d;
  halt_cause_e       cause_q, cause_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] sys_q, sys_d;
  logic [STAGES-1:0] ill_q, ill_d;
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];

  logic              in_valid;
  logic              in_sys;
  logic              in_ill;
  logic [CTRL_W-1:0] in_ctrl;

  // Accept from ID only while running and not stalled
  always_comb begin
    id_ready = id_valid & ~stall_id & (state_q == ST_RUN);
    in_sys   = id_ready & dec_sys;
    in_ill   = id_ready & dec_ill & TRAP_ILL;
    in_valid = id_ready & (~dec_ill | TRAP_ILL);
    in_ctrl  = in_valid ? dec_ctrl : '0;
  end

  // Next contents of every stage: a flush or an empty source yields a bubble
  always_comb begin
    valid_d = '0;
    sys_d   = '0;
    ill_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      ctrl_d[k] = '0;
    end
    if (!flush[0]) begin
      valid_d[0] = in_valid;
      sys_d[0]   = in_sys;
      ill_d[0]   = in_ill;
      ctrl_d[0]  = in_ctrl;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (!flush[k]) begin
        valid_d[k] = valid_q[k-1];
        sys_d[k]   = sys_q[k-1];
        ill_d[k]   = ill_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
      end
    end
  end

  logic mark_killed;
  logic mark_leaving;
  logic others_idle;

  // Halt FSM: enter DRAIN on a marked slot, fall back if it is flushed,
  // halt once it leaves the last stage with nothing else in flight
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    mark_killed  = 1'b0;
    others_idle  = 1'b1;
    mark_leaving = sys_q[STAGES-1] | ill_q[STAGES-1];
    for (int k = 1; k < STAGES; k++) begin
      if (flush[k] && (sys_q[k-1] || ill_q[k-1])) begin
        mark_killed = 1'b1;
      end
    end
    for (int k = 0; k < STAGES - 1; k++) begin
      if (valid_q[k]) begin
        others_idle = 1'b0;
      end
    end
    case (state_q)
      ST_RUN: begin
        if ((in_sys || in_ill) && !flush[0]) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mark_killed) begin
          state_d = ST_RUN;
        end else if (mark_leaving && others_idle) begin
          state_d = ST_HALT;
          cause_d = sys_q[STAGES-1] ? CAUSE_SYS : CAUSE_ILL;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, cause, markers and stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
      valid_q <= '0;
      sys_q   <= '0;
      ill_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      valid_q <= valid_d;
      sys_q   <= sys_d;
      ill_q   <= ill_d;
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= ctrl_d[k];
      end
    end
  end

  // Flatten the stage bundles onto the output bus
  always_comb begin
    stg_ctrl = '0;
    for (int k = 0; k < STAGES; k++) begin
      stg_ctrl[k*CTRL_W +: CTRL_W] = ctrl_q[k];
    end
  end

  assign stg_valid  = valid_q;
  assign halted     = (state_q == ST_HALT);
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit (STAGES=3). Expected stage-0 slots are
// queued when stimulus is driven and popped when the edge produces them;
// a three-entry expected pipe follows them into the later stages.
module tb_ctrl_pipe_unit;

  localparam int STAGES = 3;
  localparam int CW     = 13;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
  } slot_t;

  logic                 clk;
  logic                 rst;
  logic                 id_valid;
  logic [4:0]           id_opcode;
  logic                 stall_id;
  logic [STAGES-1:0]    flush;
  logic                 id_ready;
  logic [STAGES*CW-1:0] stg_ctrl;
  logic [STAGES-1:0]    stg_valid;
  logic                 halted;
  logic [1:0]           halt_cause;

  logic                 nt_id_ready;
  logic [STAGES*CW-1:0] nt_stg_ctrl;
  logic [STAGES-1:0]    nt_stg_valid;
  logic                 nt_halted;
  logic [1:0]           nt_halt_cause;

  int    checks;
  int    errors;
  slot_t exp_q[$];
  slot_t exp_stg[STAGES];

  ctrl_pipe_unit #(.STAGES(STAGES), .CTRL_W(CW), .TRAP_ILL(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .stall_id   (stall_id),
    .flush      (flush),
    .id_ready   (id_ready),
    .stg_ctrl   (stg_ctrl),
    .stg_valid  (stg_valid),
    .halted     (halted),
    .halt_cause (halt_cause)
  );

  ctrl_pipe_unit #(.STAGES(STAGES), .CTRL_W(CW), .TRAP_ILL(1'b0)) dut_nt (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .stall_id   (stall_id),
    .flush      (flush),
    .id_ready   (nt_id_ready),
    .stg_ctrl   (nt_stg_ctrl),
    .stg_valid  (nt_stg_valid),
    .halted     (nt_halted),
    .halt_cause (nt_halt_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode written out as literal bundles
  function automatic slot_t model(input logic [4:0] opc);
    slot_t s;
    s.v = 1'b1;
    case (opc)
      5'b01100: s.c = 13'h0220;
      5'b00000: s.c = 13'h0C60;
      5'b01000: s.c = 13'h00C0;
      5'b11000: s.c = 13'h1100;
      5'b00100: s.c = 13'h0270;
      5'b11011: s.c = 13'h1364;
      5'b11001: s.c = 13'h0264;
      5'b00101: s.c = 13'h006C;
      5'b01101: s.c = 13'h0262;
      default:  s.c = 13'h0000;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    exp_q.delete();
    for (int k = 0; k < STAGES; k++) exp_stg[k] = '0;
  endtask

  task automatic checkOutput(input logic [STAGES-1:0] fl);
    slot_t s;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      s = '0;
    end else begin
      s = exp_q.pop_front();
    end
    for (int k = STAGES - 1; k > 0; k--) exp_stg[k] = fl[k] ? slot_t'('0) : exp_stg[k-1];
    exp_stg[0] = s;
    for (int k = 0; k < STAGES; k++) begin
      chk($sformatf("stg%0d_valid", k), 16'(stg_valid[k]), 16'(exp_stg[k].v));
      chk($sformatf("stg%0d_ctrl", k), 16'(stg_ctrl[k*CW +: CW]), 16'(exp_stg[k].c));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] opc, input logic st,
                               input logic [STAGES-1:0] fl, input logic exp_rdy);
    slot_t s;
    id_valid  = v;
    id_opcode = opc;
    stall_id  = st;
    flush     = fl;
    #2;
    chk("id_ready", 16'(id_ready), 16'(exp_rdy));
    if (fl[0] || !exp_rdy) s = '0;
    else s = model(opc);
    exp_q.push_back(s);
    @(posedge clk);
    #1;
    checkOutput(fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'b00000, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    id_valid  = 1'b0;
    id_opcode = 5'b00000;
    stall_id  = 1'b0;
    flush     = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearModel();
    rst       = 1'b1;
    id_valid  = 1'b0;
    id_opcode = 5'b00000;
    stall_id  = 1'b0;
    flush     = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("[TB] reset state");
    chk("rst_valid", 16'(stg_valid), 16'h0);
    chk("rst_ctrl", 16'(stg_ctrl[15:0]), 16'h0);
    chk("rst_ctrl_hi", 16'(stg_ctrl[STAGES*CW-1:16]), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_cause", 16'(halt_cause), 16'h0);
    chk("rst_id_ready", 16'(id_ready), 16'h0);
    rst = 1'b0;

    $display("[TB] LOAD through the pipe");
    applyStimulus(1'b1, 5'b00000, 1'b0, 3'b000, 1'b1);
    chk("load_ex", 16'(stg_ctrl[0 +: CW]), 16'h0C60);
    idle(2);
    chk("load_wb", 16'(stg_ctrl[2*CW +: CW]), 16'h0C60);
    chk("load_wb_valid", 16'(stg_valid[2]), 16'h1);

    $display("[TB] ADD, two stalled cycles, SW");
    applyStimulus(1'b1, 5'b01100, 1'b0, 3'b000, 1'b1);
    applyStimulus(1'b1, 5'b01000, 1'b1, 3'b000, 1'b0);
    applyStimulus(1'b1, 5'b01000, 1'b1, 3'b000, 1'b0);
    applyStimulus(1'b1, 5'b01000, 1'b0, 3'b000, 1'b1);
    chk("sw_ex", 16'(stg_ctrl[0 +: CW]), 16'h00C0);
    chk("add_wb", 16'(stg_ctrl[2*CW +: CW]), 16'h0000);
    idle(3);

    $display("[TB] JAL flushed out of EX and MEM");
    applyStimulus(1'b1, 5'b11011, 1'b0, 3'b000, 1'b1);
    chk("jal_ex", 16'(stg_ctrl[0 +: CW]), 16'h1364);
    applyStimulus(1'b1, 5'b00100, 1'b0, 3'b011, 1'b1);
    chk("jal_flushed_valid", 16'(stg_valid[1:0]), 16'h0);
    chk("jal_flushed_ctrl", 16'(stg_ctrl[2*CW-1:0]), 16'h0);
    applyStimulus(1'b1, 5'b00100, 1'b1, 3'b001, 1'b0);
    idle(3);

    $display("[TB] ECALL drains and halts");
    applyStimulus(1'b1, 5'b11100, 1'b0, 3'b000, 1'b1);
    chk("ecall_halted_n1", 16'(halted), 16'h0);
    applyStimulus(1'b1, 5'b01100, 1'b0, 3'b000, 1'b0);
    chk("ecall_halted_n2", 16'(halted), 16'h0);
    applyStimulus(1'b1, 5'b01100, 1'b0, 3'b000, 1'b0);
    chk("ecall_halted_n3", 16'(halted), 16'h0);
    chk("ecall_cause_n3", 16'(halt_cause), 16'h0);
    applyStimulus(1'b1, 5'b01100, 1'b0, 3'b000, 1'b0);
    chk("ecall_halted", 16'(halted), 16'h1);
    chk("ecall_cause", 16'(halt_cause), 16'h1);
    applyStimulus(1'b1, 5'b01100, 1'b0, 3'b000, 1'b0);
    chk("halt_held", 16'(halted), 16'h1);
    doReset();

    $display("[TB] ECALL on the wrong path");
    applyStimulus(1'b1, 5'b11100, 1'b0, 3'b000, 1'b1);
    applyStimulus(1'b1, 5'b01100, 1'b0, 3'b010, 1'b0);
    applyStimulus(1'b1, 5'b01100, 1'b0, 3'b000, 1'b1);
    chk("wrongpath_halted", 16'(halted), 16'h0);
    applyStimulus(1'b1, 5'b11100, 1'b0, 3'b001, 1'b1);
    applyStimulus(1'b1, 5'b01101, 1'b0, 3'b000, 1'b1);
    idle(4);
    chk("wrongpath_still_run", 16'(halted), 16'h0);

    $display("[TB] illegal opcode");
    applyStimulus(1'b1, 5'b11111, 1'b0, 3'b000, 1'b1);
    chk("nt_ill_valid", 16'(nt_stg_valid[0]), 16'h0);
    chk("nt_ill_ctrl", 16'(nt_stg_ctrl[0 +: CW]), 16'h0);
    idle(3);
    chk("ill_halted", 16'(halted), 16'h1);
    chk("ill_cause", 16'(halt_cause), 16'h2);
    chk("nt_not_halted", 16'(nt_halted), 16'h0);
    chk("nt_cause", 16'(nt_halt_cause), 16'h0);
    id_valid  = 1'b1;
    id_opcode = 5'b01100;
    #2;
    chk("nt_id_ready", 16'(nt_id_ready), 16'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_halted", 16'(halted), 16'h0);
    chk("async_rst_cause", 16'(halt_cause), 16'h0);
    chk("async_rst_valid", 16'(stg_valid), 16'h0);
    chk("async_rst_ready", 16'(id_ready), 16'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
